maxpool_stream_ctrl: RTL and testbench

Streaming 2×2/stride-2 max-pool controller for the CNN pipeline. It accepts a feature map one signed pixel per handshake, in channel-major raster order (channel, row, column), and buffers one input row. Each complete 2×2 window is issued to a 4-input signed-max unit, and the pooled map is emitted in the same raster order with valid/ready backpressure. It sits between a convolution layer's output stream and the next layer's input.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/pool_max4.sv | 21 ++
 rtl/maxpool_stream_ctrl.sv | 161 ++++++++++++++++
 tb/tb_maxpool_stream_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types: controller state encoding and counter-width helper.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_max4.sv
// Combinational signed maximum of four pixels as a two-level compare tree.
module pool_max4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_max
);

  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_cd;

  always_comb begin
    w_ab  = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
    w_cd  = ($signed(i_c) > $signed(i_d)) ? i_c : i_d;
    o_max = ($signed(w_ab) > $signed(w_cd)) ? w_ab : w_cd;
  end

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streaming 2x2/stride-2 max-pool controller with one-row line buffer.
// Define MAXPOOL_CTRL_RELU_EN to clamp negative pooled values to zero.
module maxpool_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned W     = 24,
  parameter int unsigned H     = 24,
  parameter int unsigned C     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned COL_W    = cnt_w(W);
  localparam int unsigned ROW_W    = cnt_w(H);
  localparam int unsigned CH_W     = cnt_w(C + 1);
  localparam int unsigned LAST_COL = 2 * (W / 2) - 1;
  localparam int unsigned LAST_ROW = 2 * (H / 2) - 1;

  state_t           r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CH_W-1:0]  r_ch;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_linebuf [W];
  logic             r_busy;
  logic             r_done;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_col_wrap;
  logic             w_row_wrap;
  logic             w_frame_end;
  logic             w_issue;
  logic             w_last_win;
  logic [COL_W-1:0] w_col_prev;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_pool;

  assign w_in_ready  = (r_state == ST_RUN) & ~(r_out_valid & ~out_ready);
  assign w_accept    = in_valid & w_in_ready;
  assign w_col_wrap  = (r_col == COL_W'(W - 1));
  assign w_row_wrap  = (r_row == ROW_W'(H - 1));
  assign w_frame_end = w_col_wrap & w_row_wrap & (r_ch == CH_W'(C - 1));
  assign w_col_prev  = r_col - COL_W'(1);

  // An odd index never exceeds 2*(N/2)-1, so odd parity alone excludes trailing row/column.
  assign w_issue    = w_accept & r_row[0] & r_col[0];
  assign w_last_win = (r_ch == CH_W'(C - 1)) & (r_row == ROW_W'(LAST_ROW)) &
                      (r_col == COL_W'(LAST_COL));

  pool_max4 #(.WIDTH(WIDTH)) u_max4 (
    .i_a   (r_linebuf[w_col_prev]),
    .i_b   (r_linebuf[r_col]),
    .i_c   (r_hold),
    .i_d   (in_data),
    .o_max (w_max)
  );

`ifdef MAXPOOL_CTRL_RELU_EN
  assign w_pool = w_max[WIDTH-1] ? '0 : w_max;
`else
  assign w_pool = w_max;
`endif

  // Even rows are parked in the line buffer for the following odd row.
  always_ff @(posedge clk) begin
    if (w_accept && !r_row[0]) begin
      r_linebuf[r_col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_ch        <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
            r_ch    <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_col <= w_col_wrap ? '0 : r_col + COL_W'(1);
            if (w_col_wrap) begin
              r_row <= w_row_wrap ? '0 : r_row + ROW_W'(1);
              if (w_row_wrap) begin
                r_ch <= r_ch + CH_W'(1);
              end
            end
            if (w_frame_end) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (!r_out_valid || out_ready) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept && r_row[0] && !r_col[0]) begin
        r_hold <= in_data;
      end

      // A new window may replace the output only when the old one is leaving.
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pool;
        r_out_last  <= w_last_win;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Bench for maxpool_stream_ctrl: three geometries against a frame-level pooling model.
`timescale 1ns/1ps
module tb_maxpool_stream_ctrl;

  localparam int NI     = 3;
  localparam int PW [NI] = '{24, 4, 5};
  localparam int PH [NI] = '{24, 4, 5};
  localparam int PC [NI] = '{6, 1, 2};
  localparam int MAXPIX = 3456;
  localparam int MAXOUT = 864;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [NI];
  logic       start     [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] in_data   [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [7:0] out_data  [NI];
  logic       out_last  [NI];

  logic [7:0] img   [NI][MAXPIX];
  int         exp_d [NI][MAXOUT];
  bit         exp_l [NI][MAXOUT];
  int         got_d [NI][MAXOUT];
  bit         got_l [NI][MAXOUT];
  int exp_n [NI];
  int exp_rd[NI];
  int acc_n [NI];
  int done_cnt[NI];
  int done_cyc[NI];
  int last_acc_cyc[NI];
  bit pend  [NI];
  bit stall [NI];
  logic [7:0] stall_d[NI];
  int cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  maxpool_stream_ctrl #(.WIDTH(8), .W(24), .H(24), .C(6)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]));
  maxpool_stream_ctrl #(.WIDTH(8), .W(4), .H(4), .C(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]));
  maxpool_stream_ctrl #(.WIDTH(8), .W(5), .H(5), .C(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last(out_last[2]));

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Expected pooled stream: floor-sized grid, max over each 2x2 block, channel-major.
  task automatic build_model(input int k);
    int w, h, c, n, base, m;
    w = PW[k]; h = PH[k]; c = PC[k]; n = 0;
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < h / 2; r++)
        for (int q = 0; q < w / 2; q++) begin
          base = ch * w * h + 2 * r * w + 2 * q;
          m = sx(img[k][base]);
          if (sx(img[k][base + 1]) > m)     m = sx(img[k][base + 1]);
          if (sx(img[k][base + w]) > m)     m = sx(img[k][base + w]);
          if (sx(img[k][base + w + 1]) > m) m = sx(img[k][base + w + 1]);
`ifdef MAXPOOL_CTRL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_d[k][n] = m;
          exp_l[k][n] = (ch == c - 1) && (r == h / 2 - 1) && (q == w / 2 - 1);
          n++;
        end
    exp_n[k] = n; exp_rd[k] = 0; acc_n[k] = 0; done_cnt[k] = 0;
    pend[k] = 0; stall[k] = 0;
  endtask

  // Stream n_pix pixels; mode 1 randomises in_valid gaps and out_ready.
  task automatic feed(input int k, input int n_pix, input int mode, input int start_at);
    int i, budget;
    bit acc;
    i = 0; budget = 0;
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    while (i < n_pix && budget < 30000) begin
      in_valid[k]  = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data[k]   = img[k][i];
      out_ready[k] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i == start_at) start[k] = 1'b1;
      @(negedge clk);
      acc = in_valid[k] & in_ready[k];
      @(posedge clk); #1;
      start[k] = 1'b0;
      if (acc) i++;
      budget++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    if (i < n_pix) chk("feed_timeout", i, n_pix);
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    out_ready[k] = 1'b1;
    while (done_cnt[k] == 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (done_cnt[k] == 0) chk("done_timeout", done_cnt[k], 1);
  endtask

  task automatic check_reset_vals(input int k);
    chk("rst_in_ready",  in_ready[k],  0);
    chk("rst_out_valid", out_valid[k], 0);
    chk("rst_out_data",  out_data[k],  0);
    chk("rst_out_last",  out_last[k],  0);
    chk("rst_busy",      busy[k],      0);
    chk("rst_done",      done[k],      0);
  endtask

  // Per-cycle compare of every instance against the model queue.
  always @(negedge clk) begin
    int idx, c, r;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n[k]) begin
        pend[k] = 0; stall[k] = 0;
        continue;
      end
      if (stall[k]) begin
        chk("hold_valid", out_valid[k], 1);
        chk("hold_data", out_data[k], stall_d[k]);
        stall[k] = 0;
      end
      if (pend[k]) begin
        chk("latency", out_valid[k], 1);
        pend[k] = 0;
      end
      if (out_valid[k] && !out_ready[k]) begin
        chk("full_in_ready", in_ready[k], 0);
        stall[k] = 1; stall_d[k] = out_data[k];
      end
      if (out_valid[k] && out_ready[k]) begin
        if (exp_rd[k] < exp_n[k]) begin
          chk("out_data", sx(out_data[k]), exp_d[k][exp_rd[k]]);
          chk("out_last", out_last[k], exp_l[k][exp_rd[k]]);
          got_d[k][exp_rd[k]] = sx(out_data[k]);
          got_l[k][exp_rd[k]] = out_last[k];
          exp_rd[k]++;
        end else begin
          n_tests++; n_fail++;
          $display("FAIL extra_out inst=%0d actual=%0d required=none", k, sx(out_data[k]));
        end
      end
      if (in_valid[k] && in_ready[k]) begin
        idx = acc_n[k];
        c = idx % PW[k];
        r = (idx / PW[k]) % PH[k];
        if ((r % 2 == 1) && (c % 2 == 1)) pend[k] = 1;
        acc_n[k]++;
        last_acc_cyc[k] = cyc;
      end
      if (done[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; start[k] = 1'b0; in_valid[k] = 1'b0;
      in_data[k] = '0; out_ready[k] = 1'b1;
      exp_n[k] = 0; exp_rd[k] = 0; acc_n[k] = 0; done_cnt[k] = 0;
      pend[k] = 0; stall[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_reset_vals(k);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    // 4x4x1 ramp
    for (int i = 0; i < 16; i++) img[1][i] = 8'(i);
    build_model(1);
    feed(1, 16, 0, -1);
    wait_done(1);
    chk("ramp_cnt", exp_rd[1], 4);
    chk("ramp_o0", got_d[1][0], 5);
    chk("ramp_o1", got_d[1][1], 7);
    chk("ramp_o2", got_d[1][2], 13);
    chk("ramp_o3", got_d[1][3], 15);
    chk("ramp_last3", int'(got_l[1][3]), 1);
    chk("ramp_last2", int'(got_l[1][2]), 0);
    chk("ramp_done", done_cnt[1], 1);
    chk("ramp_busy_after", busy[1], 0);

    // Signed window {-128,-3,-100,-1}; remaining pixels -50
    for (int i = 0; i < 16; i++) img[1][i] = 8'hCE;
    img[1][0] = 8'h80; img[1][1] = 8'hFD; img[1][4] = 8'h9C; img[1][5] = 8'hFF;
`ifdef MAXPOOL_CTRL_RELU_EN
    lit = 0;
`else
    lit = -1;
`endif
    build_model(1);
    chk("model_signed", exp_d[1][0], lit);
    feed(1, 16, 0, -1);
    wait_done(1);
    chk("signed_o0", got_d[1][0], lit);
    chk("signed_cnt", exp_rd[1], 4);

    // Start pulsed mid-frame is ignored
    for (int i = 0; i < 16; i++) img[1][i] = 8'(i);
    build_model(1);
    feed(1, 16, 0, 7);
    wait_done(1);
    chk("restart_cnt", exp_rd[1], 4);
    chk("restart_o3", got_d[1][3], 15);
    chk("restart_done", done_cnt[1], 1);

    // 5x5x2: trailing row/column dropped
    for (int i = 0; i < 50; i++) img[2][i] = 8'(i);
    build_model(2);
    feed(2, 50, 0, -1);
    wait_done(2);
    chk("odd_cnt", exp_rd[2], 8);
    chk("odd_acc", acc_n[2], 50);
    chk("odd_o0", got_d[2][0], 6);
    chk("odd_o3", got_d[2][3], 18);
    chk("odd_o7", got_d[2][7], 43);
    chk("odd_done_lat", done_cyc[2] - last_acc_cyc[2], 2);
    chk("odd_done", done_cnt[2], 1);

    // 24x24x6: abort in channel 3, then a clean random frame with random backpressure
    for (int i = 0; i < MAXPIX; i++) img[0][i] = 8'(i * 7);
    build_model(0);
    feed(0, 3 * 576 + 100, 1, -1);
    chk("abort_busy", busy[0], 1);
    @(negedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    check_reset_vals(0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt[0], 0);
    rst_n[0] = 1'b1;
    for (int i = 0; i < MAXPIX; i++) img[0][i] = 8'($urandom);
    build_model(0);
    feed(0, MAXPIX, 1, -1);
    wait_done(0);
    chk("full_cnt", exp_rd[0], 864);
    chk("full_last", int'(got_l[0][863]), 1);
    chk("full_done", done_cnt[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
